// File: rtl/alu_pkg.sv
// Shared ALU select codes, op encoding and sequencer state type for the
// iterative MUL/DIVU/REMU controller and any later signed-divide variant.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    typedef enum logic [1:0] {
        MUL  = 2'b00,
        DIVU = 2'b01,
        REMU = 2'b10,
        RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_iter_ctrl_div_step.sv
// One restoring-division step: shifted partial remainder, compare against the
// divisor, quotient bit and the remainder to keep.
module div_step
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_dvd_msb,
    input  logic [XLEN-1:0] i_divisor,
    input  logic [XLEN-1:0] i_alu_res,
    output logic [XLEN-1:0] o_rem_sh,
    output logic            o_ge,
    output logic            o_q_bit,
    output logic [XLEN-1:0] o_rem_nxt
);

    assign o_rem_sh  = {i_rem[XLEN-2:0], i_dvd_msb};
    // The bit shifted out of the remainder is part of the true partial
    // remainder; when set, it already exceeds any XLEN-bit divisor.
    assign o_ge      = i_rem[XLEN-1] | (o_rem_sh >= i_divisor);
    assign o_q_bit   = o_ge;
    assign o_rem_nxt = o_ge ? i_alu_res : o_rem_sh;

endmodule

// File: rtl/alu_iter_ctrl.sv
// Iterative MUL (low half) / DIVU / REMU sequencer borrowing the shared ALU.
// Define ALU_ITER_EARLY_OUT_EN to end MUL as soon as the multiplier runs out.
module alu_iter_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    input  logic [XLEN-1:0] alu_res,
    output logic [3:0]      alu_sel,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic            alu_owned,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state
);

    // Handshake: start is a request pulse honoured only in IDLE (flush wins);
    // done pulses for one cycle in FIN unless flush is high in that cycle.

    state_e            r_state, w_state_nxt;
    op_e               r_op;
    logic [XLEN-1:0]   r_acc;    // MUL accumulator / division remainder
    logic [XLEN-1:0]   r_opnd;   // MUL multiplicand / divisor
    logic [XLEN-1:0]   r_shift;  // MUL multiplier / dividend becoming quotient
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;

    op_e               w_op;
    logic              w_accept, w_exc, w_last, w_is_mul, w_load_res;
    logic [XLEN-1:0]   w_exc_res, w_mpl_sh, w_acc_nxt, w_shift_nxt, w_run_res;
    logic [XLEN-1:0]   w_rem_sh, w_rem_nxt;
    logic              w_ge, w_q_bit;

    div_step #(.XLEN(XLEN)) u_div_step (
        .i_rem     (r_acc),
        .i_dvd_msb (r_shift[XLEN-1]),
        .i_divisor (r_opnd),
        .i_alu_res (alu_res),
        .o_rem_sh  (w_rem_sh),
        .o_ge      (w_ge),
        .o_q_bit   (w_q_bit),
        .o_rem_nxt (w_rem_nxt)
    );

    assign w_op     = op_e'(op);
    assign w_accept = start && !flush;
    assign w_is_mul = (r_op == MUL);
    assign w_mpl_sh = r_shift >> 1;

`ifdef ALU_ITER_EARLY_OUT_EN
    assign w_exc  = (w_op == RSVD) || (rs2 == '0);
    assign w_last = (r_cnt == CNT_W'(XLEN-1)) || (w_is_mul && (w_mpl_sh == '0));
`else
    assign w_exc  = (w_op == RSVD) || ((w_op != MUL) && (rs2 == '0));
    assign w_last = (r_cnt == CNT_W'(XLEN-1));
`endif

    always_comb begin
        w_exc_res = '0;
        case (w_op)
            DIVU:    w_exc_res = '1;
            REMU:    w_exc_res = rs1;
            default: w_exc_res = '0;
        endcase
    end

    assign w_acc_nxt   = w_is_mul ? (r_shift[0] ? alu_res : r_acc) : w_rem_nxt;
    assign w_shift_nxt = w_is_mul ? w_mpl_sh : {r_shift[XLEN-2:0], w_q_bit};
    assign w_run_res   = (r_op == DIVU) ? w_shift_nxt : w_acc_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_load_res  = 1'b0;
        alu_sel     = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_owned   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_exc ? FIN : RUN;
                    w_load_res  = w_exc;
                end
            end
            RUN: begin
                busy      = 1'b1;
                alu_owned = 1'b1;
                alu_b     = r_opnd;
                if (w_is_mul) begin
                    alu_sel = ALU_ADD;
                    alu_a   = r_acc;
                end else begin
                    alu_sel = ALU_SUB;
                    alu_a   = w_rem_sh;
                end
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = FIN;
                    w_load_res  = 1'b1;
                end
            end
            FIN: begin
                busy        = 1'b1;
                done        = !flush;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= MUL;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_res)
                r_result <= (r_state == IDLE) ? w_exc_res : w_run_res;
            if (r_state == IDLE && w_accept) begin
                r_op    <= w_op;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_opnd  <= (w_op == MUL) ? rs1 : rs2;
                r_shift <= (w_op == MUL) ? rs2 : rs1;
            end else if (r_state == RUN) begin
                r_acc   <= w_acc_nxt;
                r_shift <= w_shift_nxt;
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_is_mul)
                    r_opnd <= r_opnd << 1;
            end
        end
    end

    assign result    = r_result;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_iter_ctrl.sv
// Directed bench for alu_iter_ctrl with a behavioural ALU and a result scoreboard.
module tb_alu_iter_ctrl;
    import alu_pkg::*;

    localparam int XLEN = 32;
`ifdef ALU_ITER_EARLY_OUT_EN
    localparam int FLUSH_CYC = 3;
`else
    localparam int FLUSH_CYC = 10;
`endif

    logic            clk = 1'b0;
    logic            rst, start, flush;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1, rs2, alu_res;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] alu_a, alu_b, result;
    logic            alu_owned, busy, done;
    logic [1:0]      dbg_state;

    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] last_res;
    int              n_pass  = 0;
    int              n_total = 0;

    alu_iter_ctrl #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .alu_res(alu_res), .alu_sel(alu_sel), .alu_a(alu_a),
        .alu_b(alu_b), .alu_owned(alu_owned), .busy(busy), .done(done),
        .result(result), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_sel)
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            default: alu_res = '0;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [XLEN-1:0] model_res(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (o)
            2'b00:   return a * b;
            2'b01:   return (b == 0) ? '1 : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [XLEN-1:0] b);
        if (o == 2'b11 || (o != 2'b00 && b == 0)) return 1;
`ifdef ALU_ITER_EARLY_OUT_EN
        if (o == 2'b00) begin
            if (b == 0) return 1;
            for (int i = XLEN-1; i >= 0; i--)
                if (b[i]) return i + 2;
        end
`endif
        return XLEN + 1;
    endfunction

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Caller is at a negedge in IDLE; returns at the first IDLE negedge after FIN.
    task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int   cyc, own, lat;
        logic seen;
        exp_q.push_back(model_res(o, a, b));
        lat = model_lat(o, b);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; own = 0; seen = 1'b0;
        while (cyc <= 100) begin
            if (alu_owned) own++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            last_res = exp_q.pop_front();
            check("latency", 32'(cyc), 32'(lat));
            check("owned_cycles", 32'(own), 32'(lat - 1));
            check("busy_at_done", 32'(busy), 32'd1);
            check("result", result, last_res);
        end else begin
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        check("idle_after", 32'(dbg_state), 32'(IDLE));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int   cyc;
        logic any_done;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
        last_res = '0;
        #1;
        check("rst_ctrl", 32'({busy, done, alu_owned, alu_sel}), 32'd0);
        check("rst_result", result, '0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'd6, 32'd7);
        run_op(2'b01, 32'd100, 32'd7);
        run_op(2'b10, 32'd100, 32'd7);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b01, 32'd5, 32'd0);
        run_op(2'b10, 32'd5, 32'd0);
        run_op(2'b11, 32'd9, 32'd3);
        run_op(2'b00, 32'd9, 32'd5);
        run_op(2'b00, 32'd1234, 32'd0);

        // flush during RUN with start held high: no done, result kept
        op = 2'b00; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1;
        any_done = 1'b0;
        for (int i = 1; i <= FLUSH_CYC; i++) begin
            @(negedge clk);
            any_done = any_done | done;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush_run_no_done", 32'({any_done, done}), 32'd0);
        check("flush_run_idle", 32'(dbg_state), 32'(IDLE));
        check("flush_run_result", result, last_res);
        @(negedge clk);
        check("flush_run_stay_idle", 32'(dbg_state), 32'(IDLE));
        run_op(2'b00, 32'd3, 32'd4);

        // flush coinciding with FIN suppresses done
        op = 2'b01; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (dbg_state != FIN && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("fin_reached", 32'(dbg_state), 32'(FIN));
        flush = 1'b1;
        #1;
        check("flush_fin_no_done", 32'(done), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_fin_idle", 32'(dbg_state), 32'(IDLE));

        // asynchronous reset in the middle of a DIVU
        op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 15; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_ctrl", 32'({busy, done, alu_owned, alu_sel}), 32'd0);
        check("arst_alu_a", alu_a, '0);
        check("arst_alu_b", alu_b, '0);
        check("arst_result", result, '0);
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b01, 32'd1000, 32'd3);

        for (int i = 0; i < 6; i++) begin
            logic [1:0]      o;
            logic [XLEN-1:0] a, b;
            o = 2'($urandom_range(0, 2));
            a = $urandom;
            b = (o == 2'b00) ? $urandom : 32'($urandom_range(1, 32'h7FFF_FFFF));
            run_op(o, a, b);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_iter_ctrl.md
Name: alu_iter_ctrl

Overview:
- Multi-cycle sequencer for MUL (low 32 bits), DIVU and REMU.
- Executes these ops iteratively on the shared integer ALU; uses only ALU add/sub codes, issued one step per cycle.
- Sits beside the EX stage. It claims the ALU through `alu_owned`, and the top-level operand/select mux honours that claim.
- Hazard logic stalls the pipeline while `busy` is high.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request pulse; sampled only in IDLE.
- op, input, 2, operation: 00 MUL, 01 DIVU, 10 REMU, 11 reserved.
- rs1, input, XLEN, multiplicand or dividend.
- rs2, input, XLEN, multiplier or divisor.
- flush, input, 1, synchronous abort.
- alu_res, input, XLEN, shared ALU result.
- alu_sel, output, 4, ALU select: 0010 add, 0110 sub.
- alu_a, output, XLEN, ALU operand A.
- alu_b, output, XLEN, ALU operand B.
- alu_owned, output, 1, this block drives the ALU this cycle.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle completion pulse.
- result, output, XLEN, final value; held until the next accepted start.

Behaviour:
- Reset (async, any state): state IDLE; all outputs and internal registers 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - `start` = 1 latches the operands and op, clears the accumulator and counter, and goes to RUN.
  - Exceptions: DIVU/REMU with `rs2` = 0, and op = 11, go straight to FIN.
  - `busy` = 0; `alu_owned` = 0; `alu_sel`/`alu_a`/`alu_b` = 0.
- RUN:
  - `busy` = 1; `alu_owned` = 1.
  - One iteration per clock; counter increments by 1.
  - After the iteration with counter = XLEN-1, go to FIN.
- MUL iteration:
  - `alu_sel` = 0010, `alu_a` = acc, `alu_b` = mcand.
  - If mplier[0] = 1, acc <= `alu_res`.
  - Always: mcand <<= 1, mplier >>= 1.
  - Results are mod 2^XLEN, with no overflow flag.
- DIVU/REMU iteration (restoring):
  - rem_sh = {rem[XLEN-2:0], dvd[XLEN-1]}.
  - `alu_sel` = 0110, `alu_a` = rem_sh, `alu_b` = divisor.
  - Local unsigned compare decides: if rem_sh >= divisor, rem <= `alu_res` and quotient bit = 1; else rem <= rem_sh and bit = 0.
  - dvd shifts left, taking in the quotient bit.
- FIN:
  - `done` = 1 for exactly one cycle; `busy` = 1; `alu_owned` = 0.
  - `result` is loaded on the FIN-entry edge:
    - MUL: acc.
    - DIVU: quotient.
    - REMU: remainder.
    - DIVU by 0: all ones.
    - REMU by 0: `rs1`.
    - op 11: 0.
  - Unconditionally return to IDLE.
- Latency, with start accepted at edge E0:
  - Normal ops: `done` is high in the cycle after edge E(XLEN), i.e. 33 cycles for XLEN = 32.
  - Divide-by-zero and op 11: `done` is high in the cycle after E0.
- `start` in RUN/FIN is ignored; no queueing.
- `flush` in RUN or FIN: next state IDLE, no `done`, `result` unchanged. `flush` has priority over `start` in the same cycle.
- Simultaneous `flush` and FIN→IDLE: still IDLE, but `done` is suppressed.
- Back-to-back: `start` is accepted in the first IDLE cycle after FIN.

Optional Feature:
- Macro: ALU_ITER_EARLY_OUT_EN.
- Defined: in MUL, when the shifted mplier becomes 0 in RUN, go to FIN on that edge. Latency becomes (index of the highest set bit of `rs2`) + 2 cycles. `rs2` = 0 goes IDLE→FIN directly. DIVU/REMU are unaffected.
- Undefined: fixed XLEN iterations for every MUL.

Decomposition:
- Shared package `alu_pkg` holds:
  - ALU select constants: ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000, ALU_OR = 4'b0001.
  - Op encoding typedef: MUL/DIVU/REMU/RSVD.
  - State typedef: IDLE/RUN/FIN.
- One sub-module is natural: `div_step`, a combinational block giving rem_sh, the compare and the quotient bit. It is reused if a signed divide is added later.

Test Plan:
- MUL: `rs1` = 6, `rs2` = 7 → `done` after 33 cycles, `result` = 42; `alu_owned` high for exactly 32 cycles.
- DIVU then REMU: 100/7 → `result` = 14, then 2. MUL 0xFFFFFFFF × 0xFFFFFFFF → `result` = 0x00000001.
- DIVU 5/0 → `done` 1 cycle after start, `result` = 0xFFFFFFFF. REMU 5/0 → `result` = 5.
- Start MUL 3×4; `flush` at cycle 10; `start` held during RUN → no `done`, IDLE next cycle, `result` keeps its previous value. A new start then works normally.
- Assert `rst` at cycle 15 of a DIVU → all outputs 0 asynchronously (before the next edge), state IDLE.
- With ALU_ITER_EARLY_OUT_EN: MUL 9×5 → `done` in the cycle after edge E3 (latency 4), `result` = 45. Without the macro: latency 33, `result` = 45.
